// File: rtl/ajc_nbit_seq_logic_shift_unit_v_if.sv
// ---------------------------------------------------------------------------
// ajc_nbit_seq_logic_shift_unit_v_if
// Request/response bundle for the logic/shift unit.
//   master : drives start, func_sel, operand_x, operand_y, const_k;
//            observes busy, done, logic_result, logic_cnvz
//   slave  : the unit itself (mirror of master)
// ---------------------------------------------------------------------------
interface ajc_nbit_seq_logic_shift_unit_v_if #(
    parameter int WIDTH = 8,
    parameter int K_W   = 3
) ();
    logic             start;
    logic [2:0]       func_sel;
    logic [WIDTH-1:0] operand_x;
    logic [WIDTH-1:0] operand_y;
    logic [K_W-1:0]   const_k;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] logic_result;
    logic [3:0]       logic_cnvz;

    modport master (
        output start, func_sel, operand_x, operand_y, const_k,
        input  busy, done, logic_result, logic_cnvz
    );

    modport slave (
        input  start, func_sel, operand_x, operand_y, const_k,
        output busy, done, logic_result, logic_cnvz
    );
endinterface

// File: rtl/ajc_nbit_seq_logic_shift_unit_v.sv
// ---------------------------------------------------------------------------
// ajc_nbit_seq_logic_shift_unit_v
// Registered logic/shift unit for the datapath ALU. XOR/AND/OR/PASS finish in
// one clock; SHL/SHR/ASR/ROL by const_k advance one bit per clock.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : slave side of the request/response interface
//          func_sel 000 XOR, 001 AND, 010 OR, 011 PASS X,
//                   100 SHL, 101 SHR, 110 ASR, 111 ROL
//          logic_cnvz = {C, N, V, Z}
// Result and flags are written on the edge that enters DONE, so they are
// already valid while done is high and are held until the next DONE.
// ---------------------------------------------------------------------------
module ajc_nbit_seq_logic_shift_unit_v #(
    parameter int WIDTH = 8,
    parameter int K_W   = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    ajc_nbit_seq_logic_shift_unit_v_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_SHL = 3'b100;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             x_msb_q, x_msb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [K_W-1:0]   cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             load_result;
    logic [WIDTH-1:0] logic_val;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       cnvz_q;
    logic             v_flag;

    // One-cycle operations; shift codes with K=0 fall through to PASS X.
    always_comb begin
        logic_val = bus.operand_x;
        case (bus.func_sel)
            3'b000:  logic_val = bus.operand_x ^ bus.operand_y;
            3'b001:  logic_val = bus.operand_x & bus.operand_y;
            3'b010:  logic_val = bus.operand_x | bus.operand_y;
            default: logic_val = bus.operand_x;
        endcase
    end

    // Next-state and datapath update. Operands are captured only in IDLE,
    // so anything driven on the bus during SHIFT is ignored.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        x_msb_d     = x_msb_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        c_d         = c_q;
        load_result = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = bus.func_sel;
                    x_msb_d = bus.operand_x[WIDTH-1];
                    c_d     = 1'b0;
                    if (!bus.func_sel[2] || bus.const_k == '0) begin
                        acc_d       = logic_val;
                        state_d     = DONE;
                        load_result = 1'b1;
                    end else begin
                        acc_d   = bus.operand_x;
                        cnt_d   = bus.const_k;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                case (op_q[1:0])
                    2'b00: {c_d, acc_d} = {acc_q, 1'b0};
                    2'b01: {acc_d, c_d} = {1'b0, acc_q};
                    2'b10: {acc_d, c_d} = {acc_q[WIDTH-1], acc_q};
                    default: begin
                        acc_d = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
                        c_d   = acc_q[WIDTH-1];
                    end
                endcase
                cnt_d = cnt_q - K_W'(1);
                if (cnt_q == K_W'(1)) begin
                    state_d     = DONE;
                    load_result = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Overflow is only meaningful for a left shift that flipped the sign.
    assign v_flag = (op_d == OP_SHL) && (acc_d[WIDTH-1] != x_msb_d);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Working registers plus the held result/flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            x_msb_q  <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            cnvz_q   <= 4'b0000;
        end else begin
            op_q    <= op_d;
            x_msb_q <= x_msb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            if (load_result) begin
                result_q <= acc_d;
                cnvz_q   <= {c_d, acc_d[WIDTH-1], v_flag, (acc_d == '0)};
            end
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == DONE);
    assign bus.logic_result = result_q;
    assign bus.logic_cnvz   = cnvz_q;

endmodule
